// File: rtl/deser_pkg.sv
// Shared types and constants for the framed serial deserializer.
// Frame: START_BIT, WIDTH data bits, optional even-parity bit, STOP_BIT.
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } deser_state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    // Bit counter only needs to reach WIDTH-1; it saturates there instead of wrapping.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/deser_shift_core.sv
// Data shift register and bit counter for one frame; MSB_FIRST picks the shift direction.
// Latency: word reflects a shifted bit one edge after shift_en; last_bit is combinational.
// Backpressure: none; the controlling FSM decides when to shift or clear.
module deser_shift_core
    import deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word,
    output logic             last_bit
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] cnt;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            word <= '0;
        end else if (clear) begin
            cnt  <= '0;
            word <= '0;
        end else if (shift_en) begin
            if (!last_bit)
                cnt <= cnt + CW'(1);
            if (MSB_FIRST != 0)
                word <= {word[WIDTH-2:0], bit_in};
            else
                word <= {bit_in, word[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// Framed serial-to-parallel receiver with a one-word holding register on a valid/ready output.
// Latency: dout_valid rises on the edge sampling the stop bit; optional parity via SERIAL_DESER_PARITY_EN.
// Backpressure: a good frame finding the holding register full and undrained is dropped and flagged as overrun.
module serial_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             overrun
`ifdef SERIAL_DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    deser_state_t     state;
    logic [WIDTH-1:0] word;
    logic             last_bit;
    logic             shift_en;
    logic             clear;

    assign shift_en = (state == DATA);
    assign clear    = (state == IDLE);

    deser_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clear    (clear),
        .bit_in   (in),
        .word     (word),
        .last_bit (last_bit)
    );

`ifdef SERIAL_DESER_PARITY_EN
    logic parity_bad;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
            parity_err <= 1'b0;
            parity_bad <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
            // A load in STOP below overrides this drain on the same edge.
            if (dout_valid && dout_ready)
                dout_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (in == START_BIT)
                        state <= DATA;
                end
                DATA: begin
                    if (last_bit) begin
`ifdef SERIAL_DESER_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    end
                end
`ifdef SERIAL_DESER_PARITY_EN
                PARITY: begin
                    parity_bad <= (^word) ^ in;
                    state      <= STOP;
                end
`endif
                STOP: begin
                    state <= IDLE;
                    if (in != STOP_BIT) begin
                        frame_err <= 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
                    end else if (parity_bad) begin
                        parity_err <= 1'b1;
`endif
                    end else if (!dout_valid || dout_ready) begin
                        dout       <= word;
                        dout_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench: one MSB-first and one LSB-first deserializer, checked with immediate assertions.
module tb_serial_deserializer;

    logic       clk;
    logic       rst;
    logic       in_a, in_b;
    logic       ready_a, ready_b;
    logic [7:0] dout_a, dout_b;
    logic       valid_a, valid_b;
    logic       ferr_a, ferr_b;
    logic       ovr_a, ovr_b;
`ifdef SERIAL_DESER_PARITY_EN
    logic       perr_a, perr_b;
`endif

    int vectors = 0;
    int miscompares = 0;

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .in         (in_a),
        .dout       (dout_a),
        .dout_valid (valid_a),
        .dout_ready (ready_a),
        .frame_err  (ferr_a),
        .overrun    (ovr_a)
`ifdef SERIAL_DESER_PARITY_EN
        ,
        .parity_err (perr_a)
`endif
    );

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in         (in_b),
        .dout       (dout_b),
        .dout_valid (valid_b),
        .dout_ready (ready_b),
        .frame_err  (ferr_b),
        .overrun    (ovr_b)
`ifdef SERIAL_DESER_PARITY_EN
        ,
        .parity_err (perr_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one serial bit into the selected DUT and sample just after the edge.
    task automatic step(input bit sel, input logic b);
        if (sel) in_b = b;
        else     in_a = b;
        @(posedge clk);
        #1;
    endtask

    // Bits go out s[7] first; returns 1 time unit after the stop-bit edge.
    task automatic send_frame(input bit sel, input logic [7:0] s, input logic stop, input bit rdy_at_stop);
        step(sel, 1'b1);
        for (int i = 7; i >= 0; i--)
            step(sel, s[i]);
`ifdef SERIAL_DESER_PARITY_EN
        step(sel, ^s);
`endif
        if (rdy_at_stop)
            ready_a = 1'b1;
        step(sel, stop);
    endtask

    initial begin
        rst = 1'b1;
        in_a = 1'b0;
        in_b = 1'b0;
        ready_a = 1'b1;
        ready_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", dout_a, 8'h00);
        check("rst_valid", valid_a, 1'b0);
        check("rst_ferr", ferr_a, 1'b0);
        check("rst_ovr", ovr_a, 1'b0);
        rst = 1'b0;
        step(0, 1'b0);

        // MSB-first A5
        send_frame(0, 8'hA5, 1'b0, 1'b0);
        check("msb_a5_dout", dout_a, 8'hA5);
        check("msb_a5_valid", valid_a, 1'b1);
        check("msb_a5_ferr", ferr_a, 1'b0);
        step(0, 1'b0);
        check("msb_a5_drain", valid_a, 1'b0);

        // LSB-first: same stream gives the palindrome A5, then first-bit-only gives 01
        send_frame(1, 8'hA5, 1'b0, 1'b0);
        check("lsb_a5_dout", dout_b, 8'hA5);
        check("lsb_a5_valid", valid_b, 1'b1);
        step(1, 1'b0);
        check("lsb_a5_drain", valid_b, 1'b0);
        send_frame(1, 8'h80, 1'b0, 1'b0);
        check("lsb_01_dout", dout_b, 8'h01);
        check("lsb_01_valid", valid_b, 1'b1);
        step(1, 1'b0);

        // Bad stop bit, then a clean frame
        send_frame(0, 8'hFF, 1'b1, 1'b0);
        check("bad_stop_ferr", ferr_a, 1'b1);
        check("bad_stop_valid", valid_a, 1'b0);
        check("bad_stop_ovr", ovr_a, 1'b0);
        step(0, 1'b0);
        check("bad_stop_pulse", ferr_a, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        check("after_bad_dout", dout_a, 8'h3C);
        check("after_bad_valid", valid_a, 1'b1);
        step(0, 1'b0);
        check("after_bad_drain", valid_a, 1'b0);

        // Overrun: 11 held, 22 dropped back-to-back
        ready_a = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b0);
        check("ovr_first_valid", valid_a, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0);
        check("ovr_pulse", ovr_a, 1'b1);
        check("ovr_dout_held", dout_a, 8'h11);
        check("ovr_ferr", ferr_a, 1'b0);
        step(0, 1'b0);
        check("ovr_pulse_end", ovr_a, 1'b0);
        check("ovr_still_valid", valid_a, 1'b1);
        ready_a = 1'b1;
        step(0, 1'b0);
        check("ovr_drained", valid_a, 1'b0);
        check("ovr_drain_dout", dout_a, 8'h11);

        // Simultaneous drain and load
        ready_a = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b0);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        check("sim_no_ovr", ovr_a, 1'b0);
        check("sim_dout", dout_a, 8'h22);
        check("sim_valid", valid_a, 1'b1);
        step(0, 1'b0);
        check("sim_drain", valid_a, 1'b0);

        // Reset mid-frame while a word is held
        ready_a = 1'b0;
        send_frame(0, 8'h77, 1'b0, 1'b0);
        check("pre_rst_dout", dout_a, 8'h77);
        step(0, 1'b1);
        step(0, 1'b1);
        step(0, 1'b0);
        step(0, 1'b1);
        step(0, 1'b1);
        rst = 1'b1;
        #2;
        check("async_rst_dout", dout_a, 8'h00);
        check("async_rst_valid", valid_a, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_a = 1'b0;
        ready_a = 1'b1;
        step(0, 1'b0);
        check("post_rst_idle", valid_a, 1'b0);
        send_frame(0, 8'h5A, 1'b0, 1'b0);
        check("post_rst_dout", dout_a, 8'h5A);
        check("post_rst_valid", valid_a, 1'b1);
        step(0, 1'b0);

`ifdef SERIAL_DESER_PARITY_EN
        // 5A has even weight, so parity 1 is wrong
        step(0, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] pv;
            pv = 8'h5A;
            step(0, pv[i]);
        end
        step(0, 1'b1);
        step(0, 1'b0);
        check("par_err", perr_a, 1'b1);
        check("par_valid", valid_a, 1'b0);
        check("par_ferr", ferr_a, 1'b0);
        step(0, 1'b0);
        check("par_pulse_end", perr_a, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
